spi_master_burst: RTL and testbench

- Parametrised next-generation SPI master with runtime-selectable mode (CPOL/CPHA), bit order, integer clock divider and one-hot chip selects.
- Runs multi-word bursts with CS held asserted across words; TX words stream in through a valid/ready handshake and RX words stream out one per word.
- Sits between the system controller (SD/codec command engines) and the physical SPI pins. Replaces fixed single-packet transfers.

---
 rtl/spi_master_burst.sv | 210 +++++++++++++++++++++
 tb/tb_spi_master_burst.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_burst.sv
// Burst SPI master: runtime CPOL/CPHA, bit order, clock divider and chip select.
// Streams TX words via valid/ready, emits one RX strobe per word, CS held across the burst.
module spi_master_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 2,
    parameter int DIV_WIDTH  = 10,
    parameter int LEN_WIDTH  = 8,
    parameter bit MOSI_IDLE  = 1'b1,
    parameter int CS_GUARD   = 2,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic [CS_W-1:0]       i_cmd_cs,
    input  logic                  i_cmd_cpol,
    input  logic                  i_cmd_cpha,
    input  logic                  i_cmd_lsb_first,
    input  logic                  i_cmd_tx_en,
    input  logic [DIV_WIDTH-1:0]  i_cmd_div,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_busy,
    output logic                  o_spi_clk,
    output logic                  o_spi_mosi,
    input  logic                  i_spi_miso,
    output logic [NUM_CS-1:0]     o_spi_cs_n
);

    localparam int TOG_W = $clog2(2 * DATA_WIDTH);
    localparam int GRD_W = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;
    localparam logic [TOG_W-1:0]     TOG_LAST = TOG_W'(2 * DATA_WIDTH - 1);
    localparam logic [GRD_W-1:0]     GRD_LAST = GRD_W'(CS_GUARD - 1);
    localparam logic [LEN_WIDTH:0]   WORDS_ONE = (LEN_WIDTH + 1)'(1);

    // IDLE wait cmd | LOAD fetch word | SETUP CS lead guard | XFER shift word | HOLD CS trail guard
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_XFER, S_HOLD} state_t;

    state_t                r_state;
    logic                  r_cpha;
    logic                  r_lsb;
    logic                  r_tx_en;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [CS_W-1:0]       r_cs;
    logic [LEN_WIDTH:0]    r_words;
    logic                  r_first;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [GRD_W-1:0]      r_grd;
    logic [TOG_W-1:0]      r_tog;
    logic [DATA_WIDTH-1:0] r_sh_tx;
    logic [DATA_WIDTH-1:0] r_sh_rx;

    logic                  w_cnt_tc;
    logic                  w_leading;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_last_tog;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic [DATA_WIDTH-1:0] w_tx_next;
    logic [NUM_CS-1:0]     w_cs_n;

    function automatic logic f_first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    // r_tog holds the index of the toggle about to happen, so even values are leading edges
    assign w_cnt_tc   = (r_cnt == r_div);
    assign w_leading  = ~r_tog[0];
    assign w_last_tog = (r_tog == TOG_LAST);
    assign w_sample   = r_cpha ? ~w_leading : w_leading;
    assign w_shift    = r_cpha ? (w_leading && (r_tog != '0)) : (!w_leading && !w_last_tog);
    assign w_rx_next  = r_lsb ? {i_spi_miso, r_sh_rx[DATA_WIDTH-1:1]}
                              : {r_sh_rx[DATA_WIDTH-2:0], i_spi_miso};
    assign w_tx_next  = r_lsb ? {1'b0, r_sh_tx[DATA_WIDTH-1:1]}
                              : {r_sh_tx[DATA_WIDTH-2:0], 1'b0};

    always_comb begin
        w_cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(r_cs) == i) w_cs_n[i] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cpha      <= 1'b0;
            r_lsb       <= 1'b0;
            r_tx_en     <= 1'b0;
            r_div       <= '0;
            r_cs        <= '0;
            r_words     <= '0;
            r_first     <= 1'b0;
            r_cnt       <= '0;
            r_grd       <= '0;
            r_tog       <= '0;
            r_sh_tx     <= '0;
            r_sh_rx     <= '0;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_tx_ready  <= 1'b0;
            o_rx_valid  <= 1'b0;
            o_rx_data   <= '0;
            o_spi_cs_n  <= '1;
            o_spi_clk   <= 1'b0;
            o_spi_mosi  <= MOSI_IDLE;
        end else begin
            o_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_cpha      <= i_cmd_cpha;
                        r_lsb       <= i_cmd_lsb_first;
                        r_tx_en     <= i_cmd_tx_en;
                        r_div       <= i_cmd_div;
                        r_cs        <= i_cmd_cs;
                        r_words     <= {1'b0, i_cmd_len} + WORDS_ONE;
                        r_first     <= 1'b1;
                        o_spi_clk   <= i_cmd_cpol;
                        o_tx_ready  <= i_cmd_tx_en;
                        o_cmd_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!r_tx_en || (o_tx_ready && i_tx_valid)) begin
                        r_sh_tx    <= r_tx_en ? i_tx_data : '0;
                        o_spi_mosi <= r_tx_en ? f_first_bit(i_tx_data, r_lsb) : MOSI_IDLE;
                        o_tx_ready <= 1'b0;
                        r_cnt      <= '0;
                        r_grd      <= '0;
                        r_tog      <= '0;
                        if (r_first) begin
                            r_first    <= 1'b0;
                            o_spi_cs_n <= w_cs_n;
                            r_state    <= S_SETUP;
                        end else begin
                            r_state    <= S_XFER;
                        end
                    end
                end
                S_SETUP: begin
                    if (w_cnt_tc) begin
                        r_cnt <= '0;
                        if (r_grd == GRD_LAST) begin
                            r_grd   <= '0;
                            r_state <= S_XFER;
                        end else begin
                            r_grd <= r_grd + GRD_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                S_XFER: begin
                    if (w_cnt_tc) begin
                        r_cnt     <= '0;
                        o_spi_clk <= ~o_spi_clk;
                        r_tog     <= r_tog + TOG_W'(1);
                        if (w_sample) r_sh_rx <= w_rx_next;
                        if (w_shift) begin
                            r_sh_tx <= w_tx_next;
                            if (r_tx_en) o_spi_mosi <= f_first_bit(w_tx_next, r_lsb);
                        end
                        if (w_last_tog) begin
                            // with CPHA=1 the final bit is captured on this same edge
                            o_rx_data  <= r_cpha ? w_rx_next : r_sh_rx;
                            o_rx_valid <= 1'b1;
                            o_spi_mosi <= MOSI_IDLE;
                            r_tog      <= '0;
                            r_words    <= r_words - WORDS_ONE;
                            if (r_words == WORDS_ONE) begin
                                r_state <= S_HOLD;
                            end else begin
                                o_tx_ready <= r_tx_en;
                                r_state    <= S_LOAD;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                S_HOLD: begin
                    if (w_cnt_tc) begin
                        r_cnt <= '0;
                        if (r_grd == GRD_LAST) begin
                            r_grd       <= '0;
                            o_spi_cs_n  <= '1;
                            o_cmd_ready <= 1'b1;
                            o_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_grd <= r_grd + GRD_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_burst.sv
// Scoreboard bench for spi_master_burst: expected RX words queued at stimulus time,
// popped by a monitor on each rx_valid; pin activity tallied per negedge.
module tb_spi_master_burst;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_cmd_len;
    logic [0:0] i_cmd_cs;
    logic       i_cmd_cpol;
    logic       i_cmd_cpha;
    logic       i_cmd_lsb_first;
    logic       i_cmd_tx_en;
    logic [9:0] i_cmd_div;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_busy;
    logic       o_spi_clk;
    logic       o_spi_mosi;
    logic       i_spi_miso;
    logic [1:0] o_spi_cs_n;

    logic       loopback;
    logic       sl_miso = 1'b0;

    always #5 i_clk = ~i_clk;

    assign i_spi_miso = loopback ? o_spi_mosi : sl_miso;

    spi_master_burst dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_len(i_cmd_len), .i_cmd_cs(i_cmd_cs),
        .i_cmd_cpol(i_cmd_cpol), .i_cmd_cpha(i_cmd_cpha),
        .i_cmd_lsb_first(i_cmd_lsb_first), .i_cmd_tx_en(i_cmd_tx_en),
        .i_cmd_div(i_cmd_div),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_busy(o_busy),
        .o_spi_clk(o_spi_clk), .o_spi_mosi(o_spi_mosi), .i_spi_miso(i_spi_miso),
        .o_spi_cs_n(o_spi_cs_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard
    logic [7:0] exp_q[$];

    // slave model: presents the next bit on each leading SCLK edge (CPHA=1 timing)
    logic [7:0] sl_q[$];
    logic       sl_en   = 1'b0;
    logic       sl_cpol = 1'b0;
    logic       sl_lsb  = 1'b0;
    logic       sl_prev = 1'b0;
    logic [7:0] sl_word = 8'h00;
    int         sl_bit  = 0;

    always @(o_spi_clk or o_spi_cs_n) begin
        if (&o_spi_cs_n) begin
            sl_bit = 0;
        end else if (sl_en && (o_spi_clk !== sl_prev) && (o_spi_clk !== sl_cpol)) begin
            if (sl_bit == 0) sl_word = (sl_q.size() > 0) ? sl_q.pop_front() : 8'h00;
            sl_miso = sl_lsb ? sl_word[sl_bit] : sl_word[7 - sl_bit];
            sl_bit  = (sl_bit == 7) ? 0 : sl_bit + 1;
        end
        sl_prev = o_spi_clk;
    end

    // pin monitor and scoreboard consumer
    int   cyc = 0, n_rise = 0, n_fall = 0, n_cs0_low = 0, n_cs1_low = 0, n_cs0_rise = 0;
    int   n_mosi_low = 0, n_txr = 0, last_rise = 0, rise_gap = 0;
    logic prev_sclk = 1'b0, prev_cs0 = 1'b1;

    always @(negedge i_clk) begin
        cyc++;
        if (o_spi_clk === 1'b1 && prev_sclk === 1'b0) begin
            n_rise++;
            rise_gap  = cyc - last_rise;
            last_rise = cyc;
        end
        if (o_spi_clk === 1'b0 && prev_sclk === 1'b1) n_fall++;
        if (o_spi_cs_n[0] === 1'b0) n_cs0_low++;
        if (o_spi_cs_n[1] === 1'b0) n_cs1_low++;
        if (o_spi_cs_n[0] === 1'b1 && prev_cs0 === 1'b0) n_cs0_rise++;
        if (o_spi_mosi === 1'b0) n_mosi_low++;
        if (o_tx_ready === 1'b1) n_txr++;
        prev_sclk = o_spi_clk;
        prev_cs0  = o_spi_cs_n[0];
        if (i_rst === 1'b0 && o_rx_valid === 1'b1) begin
            if (exp_q.size() == 0) check("rx_unexpected_word", {24'h0, o_rx_data}, 32'hDEAD);
            else check("rx_data", {24'h0, o_rx_data}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic cs, input logic cpol,
                            input logic cpha, input logic lsb, input logic txen,
                            input logic [9:0] div);
        int t = 0;
        while (!o_cmd_ready && t < 2000) begin step(); t++; end
        if (t >= 2000) check("cmd_ready_timeout", 0, 1);
        i_cmd_len = len; i_cmd_cs = cs; i_cmd_cpol = cpol; i_cmd_cpha = cpha;
        i_cmd_lsb_first = lsb; i_cmd_tx_en = txen; i_cmd_div = div;
        i_cmd_valid = 1'b1;
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int t = 0;
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        while (!o_tx_ready && t < 2000) begin step(); t++; end
        if (t >= 2000) check("tx_ready_timeout", 0, 1);
        step();
        i_tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (o_busy && t < 5000) begin step(); t++; end
        if (t >= 5000) check("busy_timeout", 0, 1);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_rise, b_fall, b_cs0, b_cs1, b_cs0r, b_mosi, b_txr, t;
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_len = '0; i_cmd_cs = '0;
        i_cmd_cpol = 1'b0; i_cmd_cpha = 1'b0; i_cmd_lsb_first = 1'b0; i_cmd_tx_en = 1'b1;
        i_cmd_div = '0; i_tx_data = '0; i_tx_valid = 1'b0; loopback = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        step();

        // reset state
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_tx_ready", o_tx_ready, 0);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_rx_data", o_rx_data, 0);
        check("rst_cs_n", o_spi_cs_n, 2'b11);
        check("rst_sclk", o_spi_clk, 0);
        check("rst_mosi", o_spi_mosi, 1);

        // mode 0, div 1, MSB first, loopback 0xA5
        exp_q.push_back(8'hA5);
        b_rise = n_rise; b_cs0 = n_cs0_low; b_cs1 = n_cs1_low;
        send_cmd(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1);
        push_tx(8'hA5);
        wait_idle();
        check("m0_rising_edges", n_rise - b_rise, 8);
        check("m0_sclk_period", rise_gap, 4);
        check("m0_cs0_low_cycles", n_cs0_low - b_cs0, 40);
        check("m0_cs1_low_cycles", n_cs1_low - b_cs1, 0);
        check("m0_words_left", exp_q.size(), 0);
        check("m0_cmd_ready", o_cmd_ready, 1);

        // mode 3, LSB first, 3-word burst against slave model
        loopback = 1'b0; sl_en = 1'b1; sl_cpol = 1'b1; sl_lsb = 1'b1;
        sl_q.push_back(8'h5A); sl_q.push_back(8'hFF); sl_q.push_back(8'h00);
        exp_q.push_back(8'h5A); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        b_cs0 = n_cs0_low; b_cs0r = n_cs0_rise;
        send_cmd(8'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd1);
        check("m3_sclk_idle_after_cmd", o_spi_clk, 1);
        push_tx(8'h01);
        push_tx(8'h80);
        push_tx(8'h3C);
        wait_idle();
        check("m3_cs0_deasserts", n_cs0_rise - b_cs0r, 1);
        check("m3_cs0_low_cycles", n_cs0_low - b_cs0, 106);
        check("m3_sclk_idle_high", o_spi_clk, 1);
        check("m3_words_left", exp_q.size(), 0);
        sl_en = 1'b0;

        // underrun: second word withheld 50 cycles
        loopback = 1'b1;
        exp_q.push_back(8'h96); exp_q.push_back(8'h3B);
        send_cmd(8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1);
        push_tx(8'h96);
        t = 0;
        while (!o_tx_ready && t < 2000) begin step(); t++; end
        check("ur_second_ready_seen", o_tx_ready, 1);
        b_rise = n_rise; b_fall = n_fall; b_cs0 = n_cs0_low; b_cs0r = n_cs0_rise;
        repeat (50) step();
        check("ur_sclk_edges", (n_rise - b_rise) + (n_fall - b_fall), 0);
        check("ur_cs0_low_cycles", n_cs0_low - b_cs0, 50);
        check("ur_cs0_no_deassert", n_cs0_rise - b_cs0r, 0);
        check("ur_sclk_level", o_spi_clk, 0);
        check("ur_tx_ready_held", o_tx_ready, 1);
        push_tx(8'h3B);
        wait_idle();
        check("ur_words_left", exp_q.size(), 0);

        // read-only burst on cs 1, mode 1, div 2; tx_valid held high throughout
        loopback = 1'b0; sl_en = 1'b1; sl_cpol = 1'b0; sl_lsb = 1'b0;
        sl_q.push_back(8'hC6); sl_q.push_back(8'h2D);
        exp_q.push_back(8'hC6); exp_q.push_back(8'h2D);
        i_tx_data = 8'h00; i_tx_valid = 1'b1;
        b_rise = n_rise; b_cs0 = n_cs0_low; b_cs1 = n_cs1_low; b_mosi = n_mosi_low; b_txr = n_txr;
        send_cmd(8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2);
        wait_idle();
        i_tx_valid = 1'b0;
        check("ro_mosi_low_cycles", n_mosi_low - b_mosi, 0);
        check("ro_tx_ready_cycles", n_txr - b_txr, 0);
        check("ro_cs0_low_cycles", n_cs0_low - b_cs0, 0);
        check("ro_cs1_low_cycles", n_cs1_low - b_cs1, 109);
        check("ro_rising_edges", n_rise - b_rise, 16);
        check("ro_words_left", exp_q.size(), 0);
        sl_en = 1'b0;

        // reset during the third bit, then a clean burst
        loopback = 1'b1;
        b_rise = n_rise;
        send_cmd(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1);
        push_tx(8'hFF);
        t = 0;
        while ((n_rise - b_rise) < 3 && t < 2000) begin step(); t++; end
        check("ab_third_bit_reached", n_rise - b_rise, 3);
        i_rst = 1'b1;
        step();
        check("ab_cs_n", o_spi_cs_n, 2'b11);
        check("ab_busy", o_busy, 0);
        check("ab_rx_valid", o_rx_valid, 0);
        check("ab_rx_data", o_rx_data, 0);
        check("ab_cmd_ready", o_cmd_ready, 1);
        check("ab_sclk", o_spi_clk, 0);
        i_rst = 1'b0;
        step();
        exp_q.push_back(8'h5C);
        send_cmd(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1);
        push_tx(8'h5C);
        wait_idle();
        check("ab_words_left", exp_q.size(), 0);

        // div 0, mode 1, then a back-to-back command held pending while busy
        exp_q.push_back(8'hC3);
        b_rise = n_rise;
        send_cmd(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0);
        push_tx(8'hC3);
        i_cmd_len = 8'd0; i_cmd_cs = 1'b0; i_cmd_cpol = 1'b0; i_cmd_cpha = 1'b1;
        i_cmd_lsb_first = 1'b0; i_cmd_tx_en = 1'b1; i_cmd_div = 10'd0;
        i_cmd_valid = 1'b1;
        t = 0;
        while (!o_cmd_ready && t < 2000) begin step(); t++; end
        check("d0_rising_edges", n_rise - b_rise, 8);
        check("d0_sclk_period", rise_gap, 2);
        check("d0_first_word_done", exp_q.size(), 0);
        exp_q.push_back(8'h81);
        step();
        check("b2b_busy", o_busy, 1);
        check("b2b_cmd_ready", o_cmd_ready, 0);
        i_cmd_valid = 1'b0;
        push_tx(8'h81);
        wait_idle();
        check("b2b_words_left", exp_q.size(), 0);

        repeat (5) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
